// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, FSM state encoding and bit-period helper.
// The receiver imports this package as well.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // Clocks per bit, never below 1 so a baud rate above the clock still yields a legal counter.
  function automatic int unsigned cycles_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
    int unsigned cpb;
    cpb = (baud_rate == 0) ? 1 : clock_freq / baud_rate;
    return (cpb < 1) ? 1 : cpb;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small FIFO with first-word-fall-through head; pointers carry an extra wrap bit
// to tell full from empty.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_ok)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1/8N2 UART transmitter: FIFO feeds a start/data/stop FSM driving a registered tx.
// Back-to-back frames are issued with no idle gap.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100,
  parameter int unsigned BAUD_RATE  = 100,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CPB  = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned CntW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CPB - 1);
  localparam logic StopMax = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 full, empty, pop, bit_end;
  logic [DATA_BITS-1:0] head;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid && in_ready),
    .wdata(in_data),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head)
  );

  assign in_ready = !full && !rst;
  assign busy     = (state_q != StIdle) || !empty;
  assign tx       = tx_q;
  assign bit_end  = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    pop     = 1'b0;
    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            stop_d  = 1'b0;
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_q == StopMax) begin
            stop_d = 1'b0;
            // Chain straight into the next start bit when more data is queued.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 100, bit rate in bits/s.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, input buffer depth in words; power of two, at least 2.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on posedge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port in_data, input, 8, byte to transmit.
REQ-008 SHALL have port in_valid, input, 1, in_data is valid.
REQ-009 SHALL have port in_ready, output, 1, block can accept a byte.
REQ-010 SHALL have port tx, output, 1, serial line; idle high; drives the downstream uart_receiver data input.
REQ-011 SHALL have port busy, output, 1, a frame is in flight or the FIFO is non-empty.

Function
REQ-012 SHALL compute CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer division), with a minimum of 1; CYCLES_PER_BIT = 1 SHALL be fully supported.
REQ-013 SHALL accept a byte on a posedge where in_valid and in_ready are both high; there SHALL be no other write path.
REQ-014 SHALL drive in_ready as "FIFO not full", combinationally from registered state, independent of in_valid.
REQ-015 SHALL block a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-016 SHALL allow push and pop in the same cycle when the FIFO is neither full nor empty; the occupancy SHALL then be unchanged.
REQ-017 SHALL use FSM states IDLE, START, DATA and STOP.
REQ-018 IDLE -> START: when the FIFO is non-empty, the FSM SHALL pop the head word into an 8-bit shift register.
REQ-019 START -> DATA: after CYCLES_PER_BIT cycles.
REQ-020 DATA -> STOP: after 8 bit periods.
REQ-021 STOP -> START: after STOP_BITS bit periods, if the FIFO is non-empty, with a pop on the same edge.
REQ-022 STOP -> IDLE: after STOP_BITS bit periods, if the FIFO is empty.
REQ-023 SHALL register tx: 0 in START, data bit (LSB first) in DATA, 1 in STOP and IDLE.
REQ-024 SHALL hold each bit on tx for exactly CYCLES_PER_BIT cycles, timed by a bit-period counter that wraps from CYCLES_PER_BIT-1 to 0.
REQ-025 SHALL use a 3-bit data-bit index, 0..7.
REQ-026 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL make tx fall at edge N+1.
REQ-027 Frame length SHALL be (9+STOP_BITS)*CYCLES_PER_BIT cycles.
REQ-028 Back-to-back bytes SHALL have no idle gap: the next start bit immediately follows the last stop-bit cycle.
REQ-029 busy SHALL equal (state != IDLE) OR (FIFO non-empty).
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-031 While rst is high, asynchronously: tx=1, in_ready=0, busy=0, state=IDLE, FIFO empty, all counters 0.
REQ-032 After rst deasserts: in_ready=1 on the first cycle; no tx activity until a byte is accepted.
REQ-033 Reset mid-frame SHALL abort the frame: tx returns high immediately and buffered bytes are discarded.

Structure
REQ-034 Shared package uart_pkg SHALL hold DATA_BITS=8, the FSM state typedef, and the CYCLES_PER_BIT computation, for reuse by uart_receiver.
REQ-035 The FIFO SHALL be one sub-module, uart_tx_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, head), with first-word-fall-through head.

Verification
REQ-036 CYCLES_PER_BIT=1, push 0x96 at edge N -> tx from edge N+1 = 0,0,1,1,0,1,0,0,1,1; then idle high, busy=0.
REQ-037 CYCLES_PER_BIT=4, push 0xA5 -> each bit held 4 cycles; 40-cycle frame; LSB first.
REQ-038 Push 0x01,0x02,0x03,0x04,0x05 in consecutive cycles, FIFO_DEPTH=4 -> in_ready drops at the point of full; all accepted bytes sent back-to-back with no idle gap, in order.
REQ-039 STOP_BITS=2, push 0xFF,0x00 -> two stop-bit periods of tx=1 between the frames.
REQ-040 Assert rst in DATA of frame 0x55 with 2 bytes queued -> tx=1 at once; after release, no frames sent; in_ready=1.
REQ-041 Loopback tx into uart_receiver (CYCLES_PER_BIT=1), send 0x3C -> receiver output matches the sent byte per its bit-order convention.
